id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the 64-bit pipelined RISC-V core. It sits directly downstream of the register file. It captures the two read operands, the immediate, the register indices and the control bundle into the ID/EX pipeline register. It also contains the load-use hazard detector, which stalls IF/ID and inserts a bubble, and a WB-to-ID write-through bypass. It honours a branch flush from EX and keeps a saturating stall counter for performance monitoring.

---
 rtl/id_ex_if.sv | 35 +++
 rtl/id_ex_stage.sv | 56 +++++
 tb/tb_id_ex_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// id_ex_if: ID-side inputs, WB bypass and EX-side outputs of the ID/EX stage
interface id_ex_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             id_use_rs1, id_use_rs2;
   logic [XLEN-1:0]  id_read_data1, id_read_data2, id_imm;
   logic [3:0]       id_funct4;
   logic [8:0]       id_ctrl;
   logic             wb_reg_write;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             ex_flush;
   logic             stall;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0]  ex_data1, ex_data2, ex_imm;
   logic [3:0]       ex_funct4;
   logic [8:0]       ex_ctrl;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_read_data1, id_read_data2,
             id_imm, id_funct4, id_ctrl, wb_reg_write, wb_rd, wb_data, ex_flush,
      input  stall, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm, ex_funct4, ex_ctrl,
             stall_count
   );

   modport slave (
      input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_read_data1, id_read_data2,
             id_imm, id_funct4, id_ctrl, wb_reg_write, wb_rd, wb_data, ex_flush,
      output stall, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm, ex_funct4, ex_ctrl,
             stall_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, WB bypass and stall counter
module id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input logic   clk,
   input logic   reset,
   id_ex_if.slave bus
);
   // ctrl bit order: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0], valid}
   logic            hazard;
   logic            bubble;
   logic [XLEN-1:0] data1, data2;

   // load in EX whose destination the ID instruction really reads; x0 never hazards
   always_comb begin
      hazard = bus.ex_ctrl[7] & bus.ex_ctrl[0] & (bus.ex_rd != 5'd0) &
               ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
      bus.stall = hazard & ~bus.ex_flush & bus.id_ctrl[0];
      bubble = bus.ex_flush | bus.stall;
      data1 = (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs1) ? bus.wb_data : bus.id_read_data1;
      data2 = (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs2) ? bus.wb_data : bus.id_read_data2;
   end

   // pipeline register: flush or stall loads an all-zero bubble, otherwise capture ID
   always_ff @(posedge clk or negedge reset) begin
      if (!reset || bubble) begin
         bus.ex_rs1    <= 5'd0;
         bus.ex_rs2    <= 5'd0;
         bus.ex_rd     <= 5'd0;
         bus.ex_data1  <= {XLEN{1'b0}};
         bus.ex_data2  <= {XLEN{1'b0}};
         bus.ex_imm    <= {XLEN{1'b0}};
         bus.ex_funct4 <= 4'd0;
         bus.ex_ctrl   <= 9'd0;
      end else begin
         bus.ex_rs1    <= bus.id_rs1;
         bus.ex_rs2    <= bus.id_rs2;
         bus.ex_rd     <= bus.id_rd;
         bus.ex_data1  <= data1;
         bus.ex_data2  <= data2;
         bus.ex_imm    <= bus.id_imm;
         bus.ex_funct4 <= bus.id_funct4;
         bus.ex_ctrl   <= bus.id_ctrl;
      end
   end

   // saturating stall-cycle counter, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         bus.stall_count <= {CNT_W{1'b0}};
      else if (bus.stall && bus.stall_count != {CNT_W{1'b1}})
         bus.stall_count <= bus.stall_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed tests of the ID/EX stage with hand-computed expectations
module tb_id_ex_stage;
   localparam int XW = 64;
   localparam int CW = 4;
   localparam logic [8:0] LD  = 9'h1A9;
   localparam logic [8:0] ADD = 9'h105;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   exp_cnt = 0;

   id_ex_if #(.XLEN(XW), .CNT_W(CW)) bus();
   id_ex_stage #(.XLEN(XW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [XW-1:0] d1,
                         input logic [XW-1:0] d2, input logic [8:0] ctrl);
      bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
      bus.id_read_data1 = d1; bus.id_read_data2 = d2;
      bus.id_imm = 64'h10; bus.id_funct4 = 4'h0; bus.id_ctrl = ctrl;
      #1;
   endtask

   task automatic test_reset();
      bus.id_rs1 = 5'($urandom); bus.id_rs2 = 5'($urandom); bus.id_rd = 5'($urandom);
      bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.id_read_data1 = {$urandom, $urandom}; bus.id_read_data2 = {$urandom, $urandom};
      bus.id_imm = {$urandom, $urandom}; bus.id_funct4 = 4'($urandom); bus.id_ctrl = 9'($urandom);
      bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 64'd0; bus.ex_flush = 1'b0;
      #23;
      checks++; if (bus.ex_data1 !== 64'd0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", bus.ex_data1); end
      checks++; if (bus.ex_ctrl !== 9'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", bus.ex_ctrl); end
      checks++; if (bus.ex_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", bus.ex_rd); end
      checks++; if (bus.stall_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.stall_count); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
      set_id(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 64'h1234, 64'h0, ADD);
      reset = 1'b1;
      step();
      checks++; if (bus.ex_data1 !== 64'h1234) begin failures++; $display("FAIL first_capture got=%h exp=1234", bus.ex_data1); end
   endtask

   task automatic test_load_use();
      set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, LD);
      step();
      checks++; if (bus.ex_ctrl !== LD || bus.ex_rd !== 5'd5) begin failures++; $display("FAIL ld_capture got=%h/%h exp=%h/5", bus.ex_ctrl, bus.ex_rd, LD); end
      set_id(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall); end
      step();
      exp_cnt++;
      checks++; if (bus.ex_ctrl !== 9'd0 || bus.ex_rd !== 5'd0) begin failures++; $display("FAIL lu_bubble got=%h/%h exp=0/0", bus.ex_ctrl, bus.ex_rd); end
      checks++; if (bus.stall_count !== CW'(exp_cnt)) begin failures++; $display("FAIL lu_count got=%0d exp=%0d", bus.stall_count, exp_cnt); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", bus.stall); end
      step();
      checks++; if (bus.ex_rs1 !== 5'd5 || bus.ex_rd !== 5'd6 || bus.ex_ctrl !== ADD) begin failures++; $display("FAIL lu_resume got=%h/%h/%h exp=5/6/%h", bus.ex_rs1, bus.ex_rd, bus.ex_ctrl, ADD); end
   endtask

   task automatic test_x0_unused();
      set_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 64'h0, 64'h0, LD);
      step();
      set_id(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", bus.stall); end
      set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, LD);
      step();
      set_id(5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 64'h0, 64'h0, ADD);
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL unused_rs2_stall got=%b exp=0", bus.stall); end
      set_id(5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL used_rs2_stall got=%b exp=1", bus.stall); end
      set_id(5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 64'h0, 64'h0, ADD);
      step();
      checks++; if (bus.ex_ctrl !== ADD || bus.ex_rd !== 5'd6) begin failures++; $display("FAIL unused_capture got=%h/%h exp=%h/6", bus.ex_ctrl, bus.ex_rd, ADD); end
   endtask

   task automatic test_flush();
      set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, LD);
      step();
      set_id(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 64'h77, 64'h0, ADD);
      bus.ex_flush = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
      step();
      checks++; if (bus.ex_ctrl !== 9'd0 || bus.ex_rd !== 5'd0 || bus.ex_data1 !== 64'd0) begin failures++; $display("FAIL flush_bubble got=%h/%h/%h exp=0/0/0", bus.ex_ctrl, bus.ex_rd, bus.ex_data1); end
      checks++; if (bus.stall_count !== CW'(exp_cnt)) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", bus.stall_count, exp_cnt); end
      bus.ex_flush = 1'b0;
   endtask

   task automatic test_bypass();
      bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'hDEAD_BEEF;
      set_id(5'd3, 5'd3, 5'd8, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
      step();
      checks++; if (bus.ex_data1 !== 64'hDEAD_BEEF) begin failures++; $display("FAIL bypass_data1 got=%h exp=deadbeef", bus.ex_data1); end
      checks++; if (bus.ex_data2 !== 64'hDEAD_BEEF) begin failures++; $display("FAIL bypass_data2 got=%h exp=deadbeef", bus.ex_data2); end
      bus.wb_rd = 5'd0;
      set_id(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
      step();
      checks++; if (bus.ex_data1 !== 64'd0 || bus.ex_data2 !== 64'd0) begin failures++; $display("FAIL bypass_x0 got=%h/%h exp=0/0", bus.ex_data1, bus.ex_data2); end
      bus.wb_rd = 5'd3;
      set_id(5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 64'h11, 64'h22, ADD);
      step();
      checks++; if (bus.ex_data1 !== 64'hDEAD_BEEF || bus.ex_data2 !== 64'h22) begin failures++; $display("FAIL bypass_one got=%h/%h exp=deadbeef/22", bus.ex_data1, bus.ex_data2); end
      bus.wb_reg_write = 1'b0;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, LD);
         step();
         set_id(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
         checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL sat_stall iter=%0d got=%b exp=1", i, bus.stall); end
         step();
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      end
      checks++; if (bus.stall_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", bus.stall_count); end
   endtask

   task automatic test_reset_mid_stall();
      set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, LD);
      step();
      set_id(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 64'h0, 64'h0, ADD);
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", bus.stall); end
      reset = 1'b0;
      #1;
      checks++; if (bus.stall !== 1'b0 || bus.ex_ctrl !== 9'd0 || bus.stall_count !== 4'd0) begin failures++; $display("FAIL mid_reset got=%b/%h/%0d exp=0/0/0", bus.stall, bus.ex_ctrl, bus.stall_count); end
      reset = 1'b1;
      step();
      checks++; if (bus.ex_rs1 !== 5'd5 || bus.ex_ctrl !== ADD || bus.stall_count !== 4'd0) begin failures++; $display("FAIL mid_reenter got=%h/%h/%0d exp=5/%h/0", bus.ex_rs1, bus.ex_ctrl, bus.stall_count, ADD); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_x0_unused();
      test_flush();
      test_bypass();
      test_saturation();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
